// File: rtl/bus_arb_pkg.sv
// Shared types for the round-robin bus arbiter.
//   arb_state_e     : arbiter FSM states
//   host_idx_width(): bits needed to index one of nr_hosts requesters (at least 1)
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        WAIT = 2'd2
    } arb_state_e;

    function automatic int unsigned host_idx_width(input int unsigned nr_hosts);
        return (nr_hosts > 1) ? unsigned'($clog2(nr_hosts)) : 32'd1;
    endfunction

endpackage

// File: rtl/bus_rr_pick.sv
// Combinational rotate-priority encoder.
//   req    : request vector, one bit per host
//   last   : index of the most recently served host (lowest priority this round)
//   winner : first requesting host searching upward from last+1 with wrap
//   valid  : at least one request present
module bus_rr_pick
    import bus_arb_pkg::*;
#(
    parameter int unsigned NrHosts  = 2,
    parameter int unsigned IdxWidth = host_idx_width(NrHosts)
) (
    input  logic [NrHosts-1:0]  req,
    input  logic [IdxWidth-1:0] last,
    output logic [IdxWidth-1:0] winner,
    output logic                valid
);

    int unsigned cand;

    // Candidates are visited from lowest to highest priority (offset NrHosts
    // down to 1), so the last hit written is the nearest host after last.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        cand   = 0;
        for (int unsigned i = 0; i < NrHosts; i++) begin
            cand = (32'(last) + NrHosts - i) % NrHosts;
            if (req[IdxWidth'(cand)]) begin
                winner = IdxWidth'(cand);
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter sharing one downstream bus port between NrHosts hosts.
// One transaction outstanding at a time; the response is routed back to the
// granted host, and a device that never answers is errored out after
// TimeoutCycles cycles in WAIT (0 disables the timeout).
//   ck_i, rst_ni            : clock, asynchronous active-low reset
//   host_req_i/addr/we/be/wdata : per-host request, held until host_gnt_o
//   host_gnt_o              : grant pulse (one-hot or zero)
//   host_rvalid_o/rdata/err : per-host response (rdata/err zero unless rvalid)
//   dev_req_o/addr/we/be/wdata  : request to the bus
//   dev_gnt_i, dev_rvalid_i, dev_rdata_i, dev_err_i : bus handshake/response
//   busy_o                  : arbiter not idle
//   stray_rsp_o             : pulse when a device response arrives outside WAIT
module bus_rr_arbiter
    import bus_arb_pkg::*;
#(
    parameter int unsigned NrHosts       = 2,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned AddressWidth  = 32,
    parameter int unsigned TimeoutCycles = 64
) (
    input  logic                                  ck_i,
    input  logic                                  rst_ni,
    input  logic [NrHosts-1:0]                    host_req_i,
    output logic [NrHosts-1:0]                    host_gnt_o,
    input  logic [NrHosts-1:0][AddressWidth-1:0]  host_addr_i,
    input  logic [NrHosts-1:0]                    host_we_i,
    input  logic [NrHosts-1:0][DataWidth/8-1:0]   host_be_i,
    input  logic [NrHosts-1:0][DataWidth-1:0]     host_wdata_i,
    output logic [NrHosts-1:0]                    host_rvalid_o,
    output logic [NrHosts-1:0][DataWidth-1:0]     host_rdata_o,
    output logic [NrHosts-1:0]                    host_err_o,
    output logic                                  dev_req_o,
    output logic [AddressWidth-1:0]               dev_addr_o,
    output logic                                  dev_we_o,
    output logic [DataWidth/8-1:0]                dev_be_o,
    output logic [DataWidth-1:0]                  dev_wdata_o,
    input  logic                                  dev_gnt_i,
    input  logic                                  dev_rvalid_i,
    input  logic [DataWidth-1:0]                  dev_rdata_i,
    input  logic                                  dev_err_i,
    output logic                                  busy_o,
    output logic                                  stray_rsp_o
);

    localparam int unsigned IdxWidth = host_idx_width(NrHosts);
    localparam int unsigned TmoWidth =
        (TimeoutCycles > 0) ? unsigned'($clog2(TimeoutCycles + 1)) : 32'd1;
    localparam logic [TmoWidth-1:0] TmoLast = TmoWidth'(TimeoutCycles - 1);

    arb_state_e            state_q, state_d;
    logic [IdxWidth-1:0]   sel_q, sel_d;
    logic [IdxWidth-1:0]   last_q, last_d;
    logic [TmoWidth-1:0]   tmo_q, tmo_d;

    logic [IdxWidth-1:0]   pick_last;
    logic [IdxWidth-1:0]   pick_winner;
    logic                  pick_valid;
    logic                  tmo_hit;

    // In WAIT the only use of the picker is the hand-over on response, where
    // the host being answered becomes the lowest-priority one.
    assign pick_last = (state_q == WAIT) ? sel_q : last_q;

    bus_rr_pick #(
        .NrHosts  (NrHosts),
        .IdxWidth (IdxWidth)
    ) u_pick (
        .req    (host_req_i),
        .last   (pick_last),
        .winner (pick_winner),
        .valid  (pick_valid)
    );

    assign tmo_hit     = (TimeoutCycles != 0) && (tmo_q == TmoLast);
    assign busy_o      = (state_q != IDLE);
    assign stray_rsp_o = dev_rvalid_i && (state_q != WAIT);

    always_ff @(posedge ck_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            sel_q   <= '0;
            last_q  <= IdxWidth'(NrHosts - 1);
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        last_d        = last_q;
        tmo_d         = tmo_q;
        dev_req_o     = 1'b0;
        dev_addr_o    = '0;
        dev_we_o      = 1'b0;
        dev_be_o      = '0;
        dev_wdata_o   = '0;
        host_gnt_o    = '0;
        host_rvalid_o = '0;
        host_rdata_o  = '0;
        host_err_o    = '0;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    sel_d   = pick_winner;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                // A withdrawn request is abandoned without presenting anything
                // downstream, so the device cannot accept a request nobody owns.
                if (!host_req_i[sel_q]) begin
                    state_d = IDLE;
                end else begin
                    dev_req_o   = 1'b1;
                    dev_addr_o  = host_addr_i[sel_q];
                    dev_we_o    = host_we_i[sel_q];
                    dev_be_o    = host_be_i[sel_q];
                    dev_wdata_o = host_wdata_i[sel_q];
                    if (dev_gnt_i) begin
                        host_gnt_o[sel_q] = 1'b1;
                        tmo_d             = '0;
                        state_d           = WAIT;
                    end
                end
            end
            WAIT: begin
                if (tmo_q != '1) begin
                    tmo_d = tmo_q + TmoWidth'(1);
                end
                if (dev_rvalid_i || tmo_hit) begin
                    host_rvalid_o[sel_q] = 1'b1;
                    if (dev_rvalid_i) begin
                        host_rdata_o[sel_q] = dev_rdata_i;
                        host_err_o[sel_q]   = dev_err_i;
                    end else begin
                        host_err_o[sel_q]   = 1'b1;
                    end
                    last_d = sel_q;
                    if (pick_valid) begin
                        sel_d   = pick_winner;
                        state_d = ADDR;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
module tb_bus_rr_arbiter;

    localparam int unsigned NH  = 2;
    localparam int unsigned DW  = 32;
    localparam int unsigned AW  = 32;
    localparam int unsigned TMO = 4;

    logic                    ck_i = 1'b0;
    logic                    rst_ni = 1'b0;
    logic [NH-1:0]           host_req_i = '0;
    logic [NH-1:0]           host_gnt_o;
    logic [NH-1:0][AW-1:0]   host_addr_i = '0;
    logic [NH-1:0]           host_we_i = '0;
    logic [NH-1:0][DW/8-1:0] host_be_i = '0;
    logic [NH-1:0][DW-1:0]   host_wdata_i = '0;
    logic [NH-1:0]           host_rvalid_o;
    logic [NH-1:0][DW-1:0]   host_rdata_o;
    logic [NH-1:0]           host_err_o;
    logic                    dev_req_o;
    logic [AW-1:0]           dev_addr_o;
    logic                    dev_we_o;
    logic [DW/8-1:0]         dev_be_o;
    logic [DW-1:0]           dev_wdata_o;
    logic                    dev_gnt_i = 1'b0;
    logic                    dev_rvalid_i = 1'b0;
    logic [DW-1:0]           dev_rdata_i = '0;
    logic                    dev_err_i = 1'b0;
    logic                    busy_o;
    logic                    stray_rsp_o;

    bus_rr_arbiter #(
        .NrHosts       (NH),
        .DataWidth     (DW),
        .AddressWidth  (AW),
        .TimeoutCycles (TMO)
    ) dut (
        .ck_i          (ck_i),
        .rst_ni        (rst_ni),
        .host_req_i    (host_req_i),
        .host_gnt_o    (host_gnt_o),
        .host_addr_i   (host_addr_i),
        .host_we_i     (host_we_i),
        .host_be_i     (host_be_i),
        .host_wdata_i  (host_wdata_i),
        .host_rvalid_o (host_rvalid_o),
        .host_rdata_o  (host_rdata_o),
        .host_err_o    (host_err_o),
        .dev_req_o     (dev_req_o),
        .dev_addr_o    (dev_addr_o),
        .dev_we_o      (dev_we_o),
        .dev_be_o      (dev_be_o),
        .dev_wdata_o   (dev_wdata_o),
        .dev_gnt_i     (dev_gnt_i),
        .dev_rvalid_i  (dev_rvalid_i),
        .dev_rdata_i   (dev_rdata_i),
        .dev_err_i     (dev_err_i),
        .busy_o        (busy_o),
        .stray_rsp_o   (stray_rsp_o)
    );

    always #5 ck_i = ~ck_i;

    typedef struct {
        int          host;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    typedef struct {
        logic [1:0]  req;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          gnt_wait;
        int          rsp_wait;   // -1: device never answers
        logic [31:0] rdata;
        logic        derr;
        int          exp_host;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    rsp_t sb[$];
    rsp_t mon_e;
    logic [1:0] mon_oh;
    vec_t vecs[6];
    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge ck_i);
        #1;
    endtask

    // Response scoreboard: every host response must match the oldest expectation.
    always @(negedge ck_i) begin
        if (rst_ni && host_rvalid_o != '0) begin
            if (sb.size() == 0) begin
                check("unexpected rsp", 64'(host_rvalid_o), 64'(0));
            end else begin
                mon_e  = sb.pop_front();
                mon_oh = 2'b01 << mon_e.host;
                check("rsp host", 64'(host_rvalid_o), 64'(mon_oh));
                check("rsp rdata", 64'(host_rdata_o[mon_e.host]), 64'(mon_e.rdata));
                check("rsp err", 64'(host_err_o[mon_e.host]), 64'(mon_e.err));
                check("rsp other rdata", 64'(host_rdata_o[1 - mon_e.host]), 64'(0));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_vec(input vec_t v);
        host_req_i = v.req;
        for (int h = 0; h < 2; h++) begin
            host_addr_i[h]  = v.addr + 32'(h) * 32'h1000;
            host_we_i[h]    = v.we;
            host_be_i[h]    = v.be;
            host_wdata_i[h] = v.wdata ^ 32'(h + 1);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        logic [1:0] oh;
        oh = 2'b01 << v.exp_host;
        cyc();
        drive_vec(v);
        #3 check("vec idle dev_req", 64'(dev_req_o), 64'(0));
        cyc();
        for (int k = 0; k < v.gnt_wait; k++) begin
            #3;
            check("vec addr dev_req", 64'(dev_req_o), 64'(1));
            check("vec addr no gnt", 64'(host_gnt_o), 64'(0));
            cyc();
        end
        dev_gnt_i = 1'b1;
        #3;
        check("vec gnt", 64'(host_gnt_o), 64'(oh));
        check("vec dev_addr", 64'(dev_addr_o), 64'(v.addr + 32'(v.exp_host) * 32'h1000));
        check("vec dev_we", 64'(dev_we_o), 64'(v.we));
        check("vec dev_be", 64'(dev_be_o), 64'(v.be));
        check("vec dev_wdata", 64'(dev_wdata_o), 64'(v.wdata ^ 32'(v.exp_host + 1)));
        if (v.rsp_wait < 0) sb.push_back('{v.exp_host, 32'h0, 1'b1});
        cyc();
        dev_gnt_i  = 1'b0;
        host_req_i = '0;
        if (v.rsp_wait >= 0) begin
            repeat (v.rsp_wait) cyc();
            dev_rvalid_i = 1'b1;
            dev_rdata_i  = v.rdata;
            dev_err_i    = v.derr;
            sb.push_back('{v.exp_host, v.exp_rdata, v.exp_err});
            cyc();
            dev_rvalid_i = 1'b0;
            dev_err_i    = 1'b0;
        end else begin
            n = 0;
            while (sb.size() != 0 && n < 10) begin
                cyc();
                n++;
            end
        end
        #3;
        check("vec rsp consumed", 64'(sb.size()), 64'(0));
        check("vec back idle", 64'(busy_o), 64'(0));
        sb.delete();
    endtask

    initial begin
        vecs[0] = '{2'b11, 32'h2000, 1'b0, 4'hF, 32'h0A0A_0000, 0,  0, 32'h1111_1111, 1'b0, 1, 32'h1111_1111, 1'b0};
        vecs[1] = '{2'b11, 32'h4000, 1'b1, 4'h3, 32'h0B0B_0000, 2,  3, 32'h2222_2222, 1'b0, 0, 32'h2222_2222, 1'b0};
        vecs[2] = '{2'b01, 32'h6000, 1'b0, 4'hC, 32'h0C0C_0000, 1,  0, 32'hBAD0_BAD0, 1'b1, 0, 32'hBAD0_BAD0, 1'b1};
        vecs[3] = '{2'b10, 32'h8000, 1'b1, 4'h1, 32'h0D0D_0000, 0,  1, 32'h3333_3333, 1'b0, 1, 32'h3333_3333, 1'b0};
        vecs[4] = '{2'b10, 32'hA000, 1'b0, 4'h8, 32'h0E0E_0000, 0,  2, 32'h4444_4444, 1'b0, 1, 32'h4444_4444, 1'b0};
        vecs[5] = '{2'b11, 32'hC000, 1'b0, 4'hF, 32'h0F0F_0000, 0, -1, 32'h5555_5555, 1'b0, 0, 32'h0000_0000, 1'b1};

        // Reset state
        cyc();
        #3;
        check("rst busy", 64'(busy_o), 64'(0));
        check("rst dev_req", 64'(dev_req_o), 64'(0));
        check("rst dev_addr", 64'(dev_addr_o), 64'(0));
        check("rst gnt", 64'(host_gnt_o), 64'(0));
        check("rst rvalid", 64'(host_rvalid_o), 64'(0));
        check("rst rdata", 64'(host_rdata_o), 64'(0));
        check("rst stray", 64'(stray_rsp_o), 64'(0));
        cyc();
        rst_ni = 1'b1;

        // Single read from host 0 with exact cycle timing
        cyc();
        host_req_i     = 2'b01;
        host_addr_i[0] = 32'h100;
        host_we_i[0]   = 1'b0;
        host_be_i[0]   = 4'hF;
        #3 check("t1 c0 gnt", 64'(host_gnt_o), 64'(0));
        cyc();
        dev_gnt_i = 1'b1;
        #3;
        check("t1 c1 dev_req", 64'(dev_req_o), 64'(1));
        check("t1 c1 dev_addr", 64'(dev_addr_o), 64'(32'h100));
        check("t1 c1 gnt", 64'(host_gnt_o), 64'(2'b01));
        cyc();
        dev_gnt_i  = 1'b0;
        host_req_i = '0;
        #3;
        check("t1 c2 rvalid", 64'(host_rvalid_o), 64'(0));
        check("t1 c2 busy", 64'(busy_o), 64'(1));
        cyc();
        dev_rvalid_i = 1'b1;
        dev_rdata_i  = 32'hDEAD_BEEF;
        sb.push_back('{0, 32'hDEAD_BEEF, 1'b0});
        #3 check("t1 c3 rvalid", 64'(host_rvalid_o), 64'(2'b01));
        cyc();
        dev_rvalid_i = 1'b0;
        #3 check("t1 idle", 64'(busy_o), 64'(0));

        // Table-driven transactions
        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Timeout exactly TMO cycles after grant
        cyc();
        host_req_i     = 2'b01;
        host_addr_i[0] = 32'h300;
        cyc();
        dev_gnt_i = 1'b1;
        #3 check("tmo gnt", 64'(host_gnt_o), 64'(2'b01));
        sb.push_back('{0, 32'h0, 1'b1});
        for (int c = 1; c <= 5; c++) begin
            cyc();
            dev_gnt_i  = 1'b0;
            host_req_i = '0;
            #3 check("tmo rvalid timing", 64'(host_rvalid_o), 64'((c == 4) ? 2'b01 : 2'b00));
        end
        check("tmo idle", 64'(busy_o), 64'(0));

        // Late response after the timeout is dropped as stray
        cyc();
        dev_rvalid_i = 1'b1;
        dev_rdata_i  = 32'hCAFE_F00D;
        #3;
        check("stray pulse", 64'(stray_rsp_o), 64'(1));
        check("stray no rvalid", 64'(host_rvalid_o), 64'(0));
        cyc();
        dev_rvalid_i = 1'b0;
        #3 check("stray one cycle", 64'(stray_rsp_o), 64'(0));

        // Selected host withdraws in ADDR
        cyc();
        host_req_i = 2'b10;
        cyc();
        host_req_i = '0;
        #3;
        check("drop no gnt", 64'(host_gnt_o), 64'(0));
        check("drop busy in addr", 64'(busy_o), 64'(1));
        cyc();
        #3;
        check("drop busy falls", 64'(busy_o), 64'(0));
        check("drop still no gnt", 64'(host_gnt_o), 64'(0));

        // Reset asserted while waiting for a response
        cyc();
        host_req_i     = 2'b10;
        host_addr_i[1] = 32'h700;
        cyc();
        dev_gnt_i = 1'b1;
        #3 check("rstw gnt", 64'(host_gnt_o), 64'(2'b10));
        cyc();
        dev_gnt_i  = 1'b0;
        host_req_i = '0;
        #3 check("rstw in wait", 64'(busy_o), 64'(1));
        cyc();
        rst_ni = 1'b0;
        #3;
        check("rstw busy", 64'(busy_o), 64'(0));
        check("rstw dev_req", 64'(dev_req_o), 64'(0));
        check("rstw gnt", 64'(host_gnt_o), 64'(0));
        check("rstw rvalid", 64'(host_rvalid_o), 64'(0));
        check("rstw stray", 64'(stray_rsp_o), 64'(0));
        cyc();
        rst_ni = 1'b1;

        // Back-to-back alternation with both hosts requesting continuously
        cyc();
        host_req_i = 2'b11;
        for (int t = 0; t < 4; t++) begin
            cyc();
            dev_gnt_i    = 1'b1;
            dev_rvalid_i = 1'b0;
            #3 check("alt gnt", 64'(host_gnt_o), 64'((t % 2 == 0) ? 2'b01 : 2'b10));
            cyc();
            dev_gnt_i    = 1'b0;
            dev_rvalid_i = 1'b1;
            dev_rdata_i  = 32'h5000 + 32'(t);
            if (t == 3) host_req_i = '0;
            sb.push_back('{t % 2, 32'h5000 + 32'(t), 1'b0});
            #3 check("alt no gnt in wait", 64'(host_gnt_o), 64'(0));
        end
        cyc();
        dev_rvalid_i = 1'b0;
        #3 check("alt idle", 64'(busy_o), 64'(0));

        cyc();
        cyc();
        check("scoreboard empty", 64'(sb.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
